// File: rtl/key_debounce.sv
// Per-key debouncer for active-low push buttons: two-flop synchronizer, hold-time
// filter, and registered press / release / long-press event pulses.
module key_debounce #(
  parameter int KEY_W        = 2,
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_value,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam int DB_W = $clog2(DEBOUNCE_CNT);
  localparam int LG_W = $clog2(LONG_CNT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CNT - 1);
  localparam logic [LG_W-1:0] LG_SAT  = LG_W'(LONG_CNT);

  logic [KEY_W-1:0] key_p0, key_p1;
  logic [DB_W-1:0]  db_cnt   [KEY_W];
  logic [LG_W-1:0]  long_cnt [KEY_W];
  logic [KEY_W-1:0] accept;
  logic [KEY_W-1:0] value_next;

  // stage p0/p1: synchronizer, idles at released (1)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_p0 <= '1;
      key_p1 <= '1;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  // The stable state is ~key_value, so "synced level differs from stable"
  // reduces to key_p1 == key_value.
  always_comb begin
    accept = '0;
    for (int i = 0; i < KEY_W; i++) begin
      accept[i] = (key_p1[i] == key_value[i]) && (db_cnt[i] == DB_LAST);
    end
    value_next = key_value ^ accept;
  end

  // stage p2: debounce counters, level and edge events
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_value   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_value   <= value_next;
      key_press   <= accept & value_next;
      key_release <= accept & ~value_next;
      for (int i = 0; i < KEY_W; i++) begin
        if (key_p1[i] != key_value[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Long-press timer runs only while the key is held on both sides of the edge,
  // so the release cycle itself can never produce a late key_long.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_long <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        long_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        key_long[i] <= 1'b0;
        if (!(key_value[i] && value_next[i])) begin
          long_cnt[i] <= '0;
        end else if (long_cnt[i] == LG_LAST) begin
          long_cnt[i] <= LG_SAT;
          key_long[i] <= 1'b1;
        end else if (long_cnt[i] != LG_SAT) begin
          long_cnt[i] <= long_cnt[i] + LG_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/long-press windows.
module tb_key_debounce;

  localparam int KEY_W        = 2;
  localparam int DEBOUNCE_CNT = 8;
  localparam int LONG_CNT     = 32;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [KEY_W-1:0] key       = 2'b11;
  logic [KEY_W-1:0] key_value, key_press, key_release, key_long;
  logic [7:0]       obs;

  int n_chk  = 0;
  int n_fail = 0;

  key_debounce #(
    .KEY_W       (KEY_W),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .LONG_CNT    (LONG_CNT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 sys_clk = ~sys_clk;

  // {long, release, press, value}, two bits each
  assign obs = {key_long, key_release, key_press, key_value};

  task automatic check(input string tag, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run(input int n, input logic [7:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, exp);
    end
  endtask

  initial begin
    // 1: reset and idle
    #50  check("reset_held_a", 8'h00);
    #100 check("reset_held_b", 8'h00);
    #50  sys_rst_n = 1'b1;
    run(100, 8'h00, "idle");

    // 2: clean press/release on key[0]
    key[0] = 1'b0;
    run(9, 8'h00, "k0_press_wait");
    run(1, 8'h05, "k0_press");
    run(1, 8'h01, "k0_held");
    key[0] = 1'b1;
    run(9, 8'h01, "k0_release_wait");
    run(1, 8'h10, "k0_release");
    run(3, 8'h00, "k0_idle");

    // 3: bounce rejection on key[1]
    key[1] = 1'b0; run(3, 8'h00, "bounce_lo3");
    key[1] = 1'b1; run(2, 8'h00, "bounce_hi");
    key[1] = 1'b0; run(5, 8'h00, "bounce_lo5");
    key[1] = 1'b1; run(2, 8'h00, "bounce_hi");
    key[1] = 1'b0; run(7, 8'h00, "bounce_lo7");
    key[1] = 1'b1; run(12, 8'h00, "bounce_settle");
    key[1] = 1'b0;
    run(9, 8'h00, "k1_press_wait");
    run(1, 8'h0A, "k1_press");
    run(2, 8'h02, "k1_held");
    key[1] = 1'b1;
    run(9, 8'h02, "k1_release_wait");
    run(1, 8'h20, "k1_release");
    run(3, 8'h00, "k1_idle");

    // 4: long press, then a short hold with no long event
    key[0] = 1'b0;
    run(9, 8'h00, "long_press_wait");
    run(1, 8'h05, "long_press");
    run(31, 8'h01, "long_wait");
    run(1, 8'h41, "long_fire");
    run(18, 8'h01, "long_no_repeat");
    key[0] = 1'b1;
    run(9, 8'h01, "long_release_wait");
    run(1, 8'h10, "long_release");
    key[0] = 1'b0;
    run(9, 8'h00, "short_press_wait");
    run(1, 8'h05, "short_press");
    run(10, 8'h01, "short_held");
    key[0] = 1'b1;
    run(9, 8'h01, "short_release_wait");
    run(1, 8'h10, "short_release");
    run(3, 8'h00, "short_idle");

    // 5: simultaneous keys
    key = 2'b00;
    run(9, 8'h00, "both_press_wait");
    run(1, 8'h0F, "both_press");
    run(1, 8'h03, "both_held");
    key = 2'b10;
    run(9, 8'h03, "k1_only_release_wait");
    run(1, 8'h21, "k1_only_release");
    run(1, 8'h01, "k0_still_held");
    key = 2'b11;
    run(9, 8'h01, "k0_late_release_wait");
    run(1, 8'h10, "k0_late_release");
    run(3, 8'h00, "both_idle");

    // 6: reset mid-count, then mid-press
    key[0] = 1'b0;
    run(7, 8'h00, "mid_count");
    sys_rst_n = 1'b0;
    #1 check("rst_mid_count", 8'h00);
    run(2, 8'h00, "rst_mid_count_held");
    sys_rst_n = 1'b1;
    run(9, 8'h00, "rst1_press_wait");
    run(1, 8'h05, "rst1_press");
    run(10, 8'h01, "rst1_held");
    sys_rst_n = 1'b0;
    #1 check("rst_mid_press_async", 8'h00);
    run(3, 8'h00, "rst_mid_press_held");
    sys_rst_n = 1'b1;
    run(9, 8'h00, "rst2_press_wait");
    run(1, 8'h05, "rst2_press");
    key[0] = 1'b1;
    run(9, 8'h01, "rst2_release_wait");
    run(1, 8'h10, "rst2_release");
    run(3, 8'h00, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
